// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// The ACC_HI state exists only when LSU_WORD_ACCESS_EN is defined.
package lsu_pkg;

    localparam int LSU_ADDR_W = 8;
    localparam int LSU_DATA_W = 8;
    localparam int LSU_RESP_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
`ifdef LSU_WORD_ACCESS_EN
        ACC_HI = 2'd2,
`endif
        RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response channel plus byte-wide data-memory port.
// master = core, slave = load/store unit, memory = data memory.
interface load_store_unit_if;
    import lsu_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic                  req_word;
    logic [LSU_ADDR_W-1:0] req_addr;
    logic [LSU_RESP_W-1:0] req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [LSU_RESP_W-1:0] resp_rdata;
    logic                  resp_err;

    logic                  mem_write;
    logic [LSU_ADDR_W-1:0] mem_address;
    logic [LSU_DATA_W-1:0] mem_datain;
    logic [LSU_DATA_W-1:0] mem_dataout;

    modport master (
        output req_valid, req_we, req_word, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_word, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_write, mem_address, mem_datain,
        input  mem_dataout
    );

    modport memory (
        input  mem_write, mem_address, mem_datain,
        output mem_dataout
    );

endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte or little-endian 16-bit accesses over a byte-wide memory.
// Define LSU_WORD_ACCESS_EN to enable 16-bit accesses; otherwise they are rejected with resp_err.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);

    localparam int RESP_W = LSU_RESP_W;

    if (ADDR_W != 8) begin : g_addr_w_check
        $error("load_store_unit supports ADDR_W = 8 only");
    end
    if (DATA_W != 8) begin : g_data_w_check
        $error("load_store_unit supports DATA_W = 8 only");
    end

    state_e              state_q;
    state_e              state_d;
    logic                accept;

    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_lo_q;
    logic [RESP_W-1:0]   rdata_q;
`ifdef LSU_WORD_ACCESS_EN
    logic                word_q;
    logic [DATA_W-1:0]   wdata_hi_q;
`else
    logic                err_q;
    logic                unused_wdata_hi;

    // Upper store byte has no destination when word accesses are disabled.
    assign unused_wdata_hi = ^bus.req_wdata[RESP_W-1:DATA_W];
`endif

    assign bus.req_ready = (state_q == IDLE);
    assign accept        = bus.req_valid && (state_q == IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next-state defaults to the current state before the case so no
    // path leaves state_d unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef LSU_WORD_ACCESS_EN
                    state_d = ACC_LO;
`else
                    state_d = bus.req_word ? RESP : ACC_LO;
`endif
                end
            end
            ACC_LO: begin
`ifdef LSU_WORD_ACCESS_EN
                state_d = word_q ? ACC_HI : RESP;
`else
                state_d = RESP;
`endif
            end
`ifdef LSU_WORD_ACCESS_EN
            ACC_HI: state_d = RESP;
`endif
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch and read-data capture; mem_dataout is stable by the closing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_lo_q <= '0;
            rdata_q    <= '0;
`ifdef LSU_WORD_ACCESS_EN
            word_q     <= 1'b0;
            wdata_hi_q <= '0;
`else
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q       <= bus.req_we;
                        addr_q     <= bus.req_addr;
                        wdata_lo_q <= bus.req_wdata[DATA_W-1:0];
                        rdata_q    <= '0;
`ifdef LSU_WORD_ACCESS_EN
                        word_q     <= bus.req_word;
                        wdata_hi_q <= bus.req_wdata[RESP_W-1:DATA_W];
`else
                        err_q      <= bus.req_word;
`endif
                    end
                end
                ACC_LO: begin
                    if (!we_q) begin
                        rdata_q[DATA_W-1:0] <= bus.mem_dataout;
                    end
                end
`ifdef LSU_WORD_ACCESS_EN
                ACC_HI: begin
                    if (!we_q) begin
                        rdata_q[RESP_W-1:DATA_W] <= bus.mem_dataout;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Memory strobes decode from state and latched request only, never from req_*.
    always_comb begin
        bus.mem_write   = 1'b0;
        bus.mem_address = '0;
        bus.mem_datain  = '0;
        case (state_q)
            ACC_LO: begin
                bus.mem_write   = we_q;
                bus.mem_address = addr_q;
                bus.mem_datain  = wdata_lo_q;
            end
`ifdef LSU_WORD_ACCESS_EN
            ACC_HI: begin
                bus.mem_write   = we_q;
                bus.mem_address = addr_q + ADDR_W'(1);
                bus.mem_datain  = wdata_hi_q;
            end
`endif
            default: ;
        endcase
    end

    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = (state_q == RESP) ? rdata_q : '0;
`ifdef LSU_WORD_ACCESS_EN
    assign bus.resp_err   = 1'b0;
`else
    assign bus.resp_err   = (state_q == RESP) && err_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver pushes expected responses,
// monitor pops and checks them; a byte-array memory model answers on the falling edge.
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          stall;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    exp_t        exp_q[$];
    bit          active;
    int          hold;
    logic [15:0] held_rdata;
    logic        held_err;

    logic [7:0] mem [256];
    bit         mem_ready;

    load_store_unit_if bus ();

    load_store_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem_ready <= 1'b1;
        end else begin
            if (bus.mem_write) mem[bus.mem_address] <= bus.mem_datain;
            bus.mem_dataout <= mem[bus.mem_address];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"},   32'(bus.req_ready),   32'h1);
        check({tag, "_resp_valid"},  32'(bus.resp_valid),  32'h0);
        check({tag, "_resp_rdata"},  32'(bus.resp_rdata),  32'h0);
        check({tag, "_resp_err"},    32'(bus.resp_err),    32'h0);
        check({tag, "_mem_write"},   32'(bus.mem_write),   32'h0);
        check({tag, "_mem_address"}, 32'(bus.mem_address), 32'h0);
        check({tag, "_mem_datain"},  32'(bus.mem_datain),  32'h0);
    endtask

    task automatic do_req(input logic we, input logic word, input logic [7:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp_rdata,
                          input logic exp_err, input int lat, input int stall, input bit push);
        exp_t e;
        bit   ok = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_word  = word;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        for (int i = 0; i < 100; i++) begin
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            fail_now("req_accept_timeout");
            bus.req_valid = 1'b0;
            return;
        end
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        e.lat     = lat;
        e.stall   = stall;
        e.acc_cyc = cyc + 1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        // Scramble request fields after acceptance; the unit must ignore them.
        bus.req_valid = 1'b0;
        bus.req_we    = ~we;
        bus.req_word  = ~word;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wdata;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req_ready && exp_q.size() == 0 && !active) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("idle_timeout");
    endtask

    initial begin : monitor
        exp_t e;
        bus.resp_ready = 1'b0;
        active = 1'b0;
        hold   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
                hold   = 0;
                bus.resp_ready = 1'b0;
            end else if (bus.resp_valid) begin
                if (!active) begin
                    active = 1'b1;
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_response");
                        hold       = 0;
                        held_rdata = bus.resp_rdata;
                        held_err   = bus.resp_err;
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_rdata",   32'(bus.resp_rdata), 32'(e.rdata));
                        check("resp_err",     32'(bus.resp_err),   32'(e.err));
                        check("resp_latency", 32'(cyc + 1 - e.acc_cyc), 32'(e.lat));
                        hold       = e.stall;
                        held_rdata = e.rdata;
                        held_err   = e.err;
                    end
                end else begin
                    check("stall_rdata",       32'(bus.resp_rdata),  32'(held_rdata));
                    check("stall_err",         32'(bus.resp_err),    32'(held_err));
                    check("stall_req_ready",   32'(bus.req_ready),   32'h0);
                    check("stall_mem_write",   32'(bus.mem_write),   32'h0);
                    check("stall_mem_address", 32'(bus.mem_address), 32'h0);
                end
                if (hold > 0) begin
                    bus.resp_ready = 1'b0;
                    hold--;
                end else begin
                    bus.resp_ready = 1'b1;
                end
            end else begin
                if (active) check("post_resp_req_ready", 32'(bus.req_ready), 32'h1);
                active = 1'b0;
                bus.resp_ready = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_word  = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 16'h0000;
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Byte traffic, including the top address and a store that must drop wdata[15:8].
        do_req(1'b1, 1'b0, 8'h10, 16'h00A5, 16'h0000, 1'b0, 2, 0, 1'b1);
        do_req(1'b0, 1'b0, 8'h10, 16'h0000, 16'h00A5, 1'b0, 2, 0, 1'b1);
        do_req(1'b1, 1'b0, 8'hFF, 16'hC33C, 16'h0000, 1'b0, 2, 0, 1'b1);
        do_req(1'b0, 1'b0, 8'hFF, 16'h0000, 16'h003C, 1'b0, 2, 0, 1'b1);
        do_req(1'b1, 1'b0, 8'h00, 16'hFF5A, 16'h0000, 1'b0, 2, 0, 1'b1);
        do_req(1'b0, 1'b0, 8'h10, 16'h0000, 16'h00A5, 1'b0, 2, 5, 1'b1);
        wait_idle();
        check("mem_10", 32'(mem[8'h10]), 32'hA5);
        check("mem_ff", 32'(mem[8'hFF]), 32'h3C);
        check("mem_00", 32'(mem[8'h00]), 32'h5A);
        check("mem_01", 32'(mem[8'h01]), 32'h00);

`ifdef LSU_WORD_ACCESS_EN
        // Word store/load wrapping from 0xFF to 0x00, then a stalled word load.
        do_req(1'b1, 1'b1, 8'hFF, 16'h1234, 16'h0000, 1'b0, 3, 0, 1'b1);
        do_req(1'b0, 1'b1, 8'hFF, 16'h0000, 16'h1234, 1'b0, 3, 0, 1'b1);
        do_req(1'b0, 1'b1, 8'h0F, 16'h0000, 16'hA500, 1'b0, 3, 3, 1'b1);
        wait_idle();
        check("word_mem_ff", 32'(mem[8'hFF]), 32'h34);
        check("word_mem_00", 32'(mem[8'h00]), 32'h12);

        // Reset while the high byte of a word store is on the bus.
        do_req(1'b1, 1'b1, 8'h20, 16'hBEEF, 16'h0000, 1'b0, 3, 0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midword_reset");
        @(negedge clk);
        #1;
        check("midword_mem_20", 32'(mem[8'h20]), 32'hEF);
        check("midword_mem_21", 32'(mem[8'h21]), 32'h00);
        rst_n = 1'b1;
`else
        // Word requests are rejected straight from IDLE without touching memory.
        do_req(1'b0, 1'b1, 8'h40, 16'h0000, 16'h0000, 1'b1, 1, 0, 1'b1);
        do_req(1'b1, 1'b1, 8'h40, 16'hBEEF, 16'h0000, 1'b1, 1, 2, 1'b1);
        do_req(1'b0, 1'b0, 8'h40, 16'h0000, 16'h0000, 1'b0, 2, 0, 1'b1);
        wait_idle();
        check("err_mem_40", 32'(mem[8'h40]), 32'h00);
        check("err_mem_41", 32'(mem[8'h41]), 32'h00);

        // Reset before the byte store reaches its write edge.
        do_req(1'b1, 1'b0, 8'h30, 16'h0077, 16'h0000, 1'b0, 2, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midbyte_reset");
        @(negedge clk);
        #1;
        check("midbyte_mem_30", 32'(mem[8'h30]), 32'h00);
        rst_n = 1'b1;
`endif

        // Unit must be fully usable after a mid-transaction reset.
        do_req(1'b0, 1'b0, 8'h10, 16'h0000, 16'h00A5, 1'b0, 2, 0, 1'b1);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
